// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared types and helpers for the button event scheduler
package btn_evt_pkg;

  // Event kinds carried on the output channel; the value 3 is never produced
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_REPEAT  = 2'd1,
    EVT_RELEASE = 2'd2
  } evt_kind_t;

  // Per-button hold/repeat state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_RPT  = 2'd2
  } btn_state_t;

  // Width of a button index; a single button still gets a one-bit id
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter
  import btn_evt_pkg::*;
#(
  parameter int N = 4,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);

  logic         hi_any;
  logic         lo_any;
  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;

  // Two passes: lowest request at or above ptr wins, otherwise lowest request overall (the wrap)
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!hi_any && req[i] && (i >= int'(ptr))) begin
        hi_any = 1'b1;
        hi_idx = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!lo_any && req[i]) begin
        lo_any = 1'b1;
        lo_idx = W'(i);
      end
    end
    gnt_any = hi_any | lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - turns debounced button levels into PRESS/REPEAT/RELEASE events on one channel
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int          NUM_BTN      = 4,
  parameter logic [31:0] HOLD_COUNT   = 32'd50_000_000,
  parameter logic [31:0] REPEAT_COUNT = 32'd10_000_000,
  localparam int         ID_W         = id_width(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [1:0]         evt_kind,
  input  logic               ovf_clr,
  output logic [NUM_BTN-1:0] overflow
);

  // Last count value before a REPEAT fires; also the saturation point while repeat is off
  localparam logic [31:0] HOLD_LAST = HOLD_COUNT - 32'd1;
  localparam logic [31:0] RPT_LAST  = REPEAT_COUNT - 32'd1;

  logic [NUM_BTN-1:0] btn_prev;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [NUM_BTN-1:0] post_vld;
  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] take;
  evt_kind_t          post_kind [NUM_BTN];
  evt_kind_t          pend_kind [NUM_BTN];

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               load;

  assign rise = btn_in & ~btn_prev;
  assign fall = ~btn_in & btn_prev;

  // Previous levels; reset to 0 so a button held through reset still yields a PRESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
    end else begin
      btn_prev <= btn_in;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_state_t  state;
    logic [31:0] cnt;
    logic        post_l;
    evt_kind_t   post_k;
    logic        pend_q;
    evt_kind_t   kind_q;
    logic        ovf_q;

    // Event this button posts this cycle; a fall always beats a REPEAT landing on the same cycle
    always_comb begin
      post_l = 1'b0;
      post_k = EVT_PRESS;
      case (state)
        ST_IDLE: begin
          if (rise[i]) begin
            post_l = 1'b1;
            post_k = EVT_PRESS;
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            post_l = 1'b1;
            post_k = EVT_RELEASE;
          end else if (repeat_en[i] && (cnt == HOLD_LAST)) begin
            post_l = 1'b1;
            post_k = EVT_REPEAT;
          end
        end
        ST_RPT: begin
          if (fall[i]) begin
            post_l = 1'b1;
            post_k = EVT_RELEASE;
          end else if (repeat_en[i] && (cnt == RPT_LAST)) begin
            post_l = 1'b1;
            post_k = EVT_REPEAT;
          end
        end
        default: begin
          post_l = 1'b0;
          post_k = EVT_PRESS;
        end
      endcase
    end

    // Hold/repeat FSM; the counter parks at its last value while repeat is disabled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise[i]) begin
              state <= ST_HELD;
              cnt   <= '0;
            end
          end
          ST_HELD: begin
            if (fall[i]) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (repeat_en[i] && (cnt == HOLD_LAST)) begin
              state <= ST_RPT;
              cnt   <= '0;
            end else if (cnt != HOLD_LAST) begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_RPT: begin
            if (fall[i]) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (repeat_en[i] && (cnt == RPT_LAST)) begin
              cnt <= '0;
            end else if (cnt != RPT_LAST) begin
              cnt <= cnt + 32'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign take[i] = load && (gnt_idx == ID_W'(i));

    // One-deep pending slot: a post into an occupied slot that is not being drained is dropped
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_q <= 1'b0;
        kind_q <= EVT_PRESS;
        ovf_q  <= 1'b0;
      end else begin
        if (post_l && (!pend_q || take[i])) begin
          pend_q <= 1'b1;
          kind_q <= post_k;
        end else if (take[i]) begin
          pend_q <= 1'b0;
        end

        if (post_l && pend_q && !take[i]) begin
          ovf_q <= 1'b1;
        end else if (ovf_clr) begin
          ovf_q <= 1'b0;
        end
      end
    end

    assign post_vld[i]  = post_l;
    assign post_kind[i] = post_k;
    assign pend[i]      = pend_q;
    assign pend_kind[i] = kind_q;
    assign overflow[i]  = ovf_q;
  end

  rr_arbiter #(
    .N (NUM_BTN),
    .W (ID_W)
  ) u_arb (
    .req     (pend),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The output register refills whenever it is empty or being handed off this cycle
  assign load = gnt_any && (!evt_valid || evt_ready);

  // Output stage and fairness pointer; the pointer moves just past whoever was served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_kind  <= 2'd0;
      rr_ptr    <= '0;
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_id    <= gnt_idx;
      evt_kind  <= pend_kind[gnt_idx];
      rr_ptr    <= (gnt_idx == ID_W'(NUM_BTN - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
